// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a multi-digit 7-segment display behind a pair of 74HC595s.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits at each snapshot.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_TICKS = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blank_mask,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done
);
    localparam int            CW        = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(SCAN_TICKS - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(NUM_DIGITS - 1);
    localparam logic [15:0]   DARK_WORD = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, SEND, HOLD, BLANK} state_t;

    state_t        state, state_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [15:0]   data_nxt;
    logic          valid_nxt, fd_nxt;
    logic [31:0]   snap_digits, snap_digits_nxt;
    logic [7:0]    snap_dp, snap_dp_nxt, snap_blank, snap_blank_nxt;
    logic          wrap;
    logic [2:0]    idx_adv;

    // Active-low segment byte with the dp bit (bit 7) off.
    function automatic logic [7:0] seg_code(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Marks the run of zero digits from the top down; digit 0 always stays visible.
    function automatic logic [7:0] lead_zero_mask(input logic [31:0] d);
        logic [7:0] m;
        logic       zero_run;
        m        = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (d[4*k +: 4] == 4'h0);
            m[k]     = zero_run;
        end
        return m;
    endfunction
`endif

    function automatic logic [15:0] encode_word(input logic [31:0] d, input logic [7:0] dp,
                                                input logic [7:0] bl, input logic [2:0] i);
        logic [7:0] seg;
        logic [7:0] dark;
        seg = seg_code(d[{i, 2'b00} +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        dark = bl | lead_zero_mask(d);
`else
        dark = bl;
`endif
        if (dp[i])   seg[7] = 1'b0;
        if (dark[i]) seg    = 8'hFF;
        return {seg, ~(8'b1 << i)};
    endfunction

    assign wrap    = (idx == LAST_IDX);
    assign idx_adv = wrap ? 3'd0 : idx + 3'd1;
    assign busy    = (state != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt       = state;
        idx_nxt         = idx;
        cnt_nxt         = cnt;
        data_nxt        = out_data;
        valid_nxt       = out_valid;
        fd_nxt          = 1'b0;
        snap_digits_nxt = snap_digits;
        snap_dp_nxt     = snap_dp;
        snap_blank_nxt  = snap_blank;

        case (state)
            IDLE: begin
                if (en) begin
                    snap_digits_nxt = digits;
                    snap_dp_nxt     = dp_mask;
                    snap_blank_nxt  = blank_mask;
                    idx_nxt         = 3'd0;
                    data_nxt        = encode_word(digits, dp_mask, blank_mask, 3'd0);
                    valid_nxt       = 1'b1;
                    state_nxt       = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (cnt == LAST_TICK) begin
                    fd_nxt    = wrap;
                    valid_nxt = 1'b1;
                    if (en) begin
                        idx_nxt   = idx_adv;
                        state_nxt = SEND;
                        // Inputs are re-sampled only at frame start so a frame never tears.
                        if (wrap) begin
                            snap_digits_nxt = digits;
                            snap_dp_nxt     = dp_mask;
                            snap_blank_nxt  = blank_mask;
                            data_nxt        = encode_word(digits, dp_mask, blank_mask, 3'd0);
                        end else begin
                            data_nxt = encode_word(snap_digits, snap_dp, snap_blank, idx_adv);
                        end
                    end else begin
                        data_nxt  = DARK_WORD;
                        state_nxt = BLANK;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            BLANK: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    idx_nxt   = 3'd0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            out_data    <= DARK_WORD;
            out_valid   <= 1'b0;
            frame_done  <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all update together at the edge.
            state       <= state_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            out_data    <= data_nxt;
            out_valid   <= valid_nxt;
            frame_done  <= fd_nxt;
            snap_digits <= snap_digits_nxt;
            snap_dp     <= snap_dp_nxt;
            snap_blank  <= snap_blank_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level display model.
module tb_seg7_scan_ctrl;
    localparam int NUM_DIGITS = 4;
    localparam int SCAN_TICKS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [31:0] digits = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  blank_mask = '0;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_valid, busy, frame_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NUM_DIGITS(NUM_DIGITS), .SCAN_TICKS(SCAN_TICKS)) dut (
        .clk(clk), .reset(reset), .en(en), .digits(digits), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lit segments (active-high, bit order gfedcba) for each hex glyph.
    localparam logic [7:0] LIT_SEGS [0:15] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    function automatic logic [15:0] model_word(input logic [31:0] d, input logic [7:0] dp,
                                               input logic [7:0] bl, input int pos);
        int         v;
        bit         dark;
        logic [7:0] seg;
        v    = int'((d >> (4 * pos)) & 32'hF);
        dark = bl[pos];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin
            int top;
            top = 0;
            for (int k = 0; k < NUM_DIGITS; k++)
                if (((d >> (4 * k)) & 32'hF) != 0) top = k;
            if (pos > top) dark = 1'b1;
        end
`endif
        if (dark) seg = 8'hFF;
        else      seg = ~(LIT_SEGS[v] | (dp[pos] ? 8'h80 : 8'h00));
        return {seg, 8'hFF - 8'(1 << pos)};
    endfunction

    // Display model: a frame of words, each presented until taken, then shown for SCAN_TICKS cycles.
    bit          m_valid = 0, m_busy = 0, m_fd = 0, m_blanking = 0;
    logic [15:0] m_data = 16'hFFFF;
    int          m_pos = 0, m_dwell = 0;
    logic [31:0] f_digits = '0;
    logic [7:0]  f_dp = '0, f_bl = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 0; m_busy = 0; m_fd = 0; m_blanking = 0;
            m_data = 16'hFFFF; m_pos = 0; m_dwell = 0;
        end else begin
            m_fd = 0;
            if (!m_busy) begin
                if (en) begin
                    f_digits = digits; f_dp = dp_mask; f_bl = blank_mask;
                    m_pos = 0; m_data = model_word(f_digits, f_dp, f_bl, 0);
                    m_valid = 1; m_busy = 1;
                end
            end else if (m_valid) begin
                if (out_ready) begin
                    m_valid = 0;
                    if (m_blanking) begin m_busy = 0; m_blanking = 0; end
                    else m_dwell = SCAN_TICKS;
                end
            end else begin
                m_dwell--;
                if (m_dwell == 0) begin
                    m_fd    = (m_pos == NUM_DIGITS - 1);
                    m_pos   = (m_pos + 1) % NUM_DIGITS;
                    m_valid = 1;
                    if (!en) begin
                        m_data = 16'hFFFF; m_blanking = 1;
                    end else begin
                        if (m_pos == 0) begin
                            f_digits = digits; f_dp = dp_mask; f_bl = blank_mask;
                        end
                        m_data = model_word(f_digits, f_dp, f_bl, m_pos);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("out_data", {16'h0, out_data}, {16'h0, m_data});
        check("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
        check("busy", {31'h0, busy}, {31'h0, m_busy});
        check("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
    end

    // Record accepted words and frame_done pulses with their cycle stamps.
    logic [15:0] acc_q[$];
    int          acc_t[$];
    int          cyc = 0;
    int          fd_count = 0;

    always @(posedge clk) begin
        cyc++;
        if (!reset && out_valid && out_ready) begin
            acc_q.push_back(out_data);
            acc_t.push_back(cyc);
        end
        if (!reset && frame_done) fd_count++;
    end

    task automatic wait_accepts(input int n);
        int budget;
        budget = 400;
        while (acc_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (acc_q.size() < n) check("accept_timeout", acc_q.size(), n);
    endtask

    task automatic restart(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                           input logic rdy);
        reset = 1'b1; en = 1'b0;
        digits = d; dp_mask = dp; blank_mask = bl; out_ready = rdy;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        acc_q.delete(); acc_t.delete(); fd_count = 0;
    endtask

    initial begin
        #1 reset = 1'b1;

        // Reset state and first frame with the ready line held high.
        restart(32'h0000_1234, 8'h00, 8'h00, 1'b1);
        check("rst_data", {16'h0, out_data}, 32'hFFFF);
        check("rst_valid", {31'h0, out_valid}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_frame_done", {31'h0, frame_done}, 0);
        en = 1'b1;
        @(negedge clk);
        check("latency_valid", {31'h0, out_valid}, 1);
        check("latency_word", {16'h0, out_data}, 32'h99FE);
        wait_accepts(4);
        check("word_d0", {16'h0, acc_q[0]}, 32'h99FE);
        check("word_d1", {16'h0, acc_q[1]}, 32'hB0FD);
        check("word_d2", {16'h0, acc_q[2]}, 32'hA4FB);
        check("word_d3", {16'h0, acc_q[3]}, 32'hF9F7);
        check("spacing_01", acc_t[1] - acc_t[0], SCAN_TICKS + 1);
        check("spacing_23", acc_t[3] - acc_t[2], SCAN_TICKS + 1);
        repeat (6) @(negedge clk);
        check("frame_done_once", fd_count, 1);

        // Decimal point and blank masks.
        restart(32'h0000_1234, 8'h02, 8'h04, 1'b1);
        en = 1'b1;
        wait_accepts(3);
        check("dp_digit1", {16'h0, acc_q[1]}, 32'h30FD);
        check("blank_digit2", {16'h0, acc_q[2]}, 32'hFFFB);

        // Stalled serializer: word must stay put, dwell starts at acceptance.
        restart(32'h0000_1234, 8'h00, 8'h00, 1'b0);
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", {31'h0, out_valid}, 1);
            check("stall_data", {16'h0, out_data}, 32'h99FE);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_accepts(2);
        check("stall_word0", {16'h0, acc_q[0]}, 32'h99FE);
        check("stall_spacing", acc_t[1] - acc_t[0], SCAN_TICKS + 1);

        // Disable during the dwell of digit 1.
        restart(32'h0000_1234, 8'h00, 8'h00, 1'b1);
        en = 1'b1;
        wait_accepts(2);
        en = 1'b0;
        wait_accepts(3);
        check("disable_dark_word", {16'h0, acc_q[2]}, 32'hFFFF);
        check("disable_idle", {31'h0, busy}, 0);
        repeat (3) @(negedge clk);
        check("disable_no_more", acc_q.size(), 3);
        en = 1'b1;
        wait_accepts(4);
        check("reenable_digit0", {16'h0, acc_q[3]}, 32'h99FE);

        // Digits changed mid-frame take effect at the next frame.
        restart(32'h0000_1234, 8'h00, 8'h00, 1'b1);
        en = 1'b1;
        wait_accepts(1);
        digits = 32'h0000_5678;
        wait_accepts(5);
        check("tear_d1", {16'h0, acc_q[1]}, 32'hB0FD);
        check("tear_d3", {16'h0, acc_q[3]}, 32'hF9F7);
        check("newframe_d0", {16'h0, acc_q[4]}, 32'h80FE);

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 24) == 0) en = ~en;
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 30) == 0) digits = $urandom();
            if ($urandom_range(0, 40) == 0) dp_mask = 8'($urandom());
            if ($urandom_range(0, 40) == 0) blank_mask = 8'($urandom() & $urandom());
            reset = ($urandom_range(0, 500) == 0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
